// File: rtl/mux_arb_pkg.sv
// Shared types and sizes for the round-robin mux arbiter.
//   arb_state_t : arbiter FSM state (IDLE, GRANT)
//   N_REQ       : number of requesters sharing the mux
//   SEL_W       : width of the mux select / requester index
package mux_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned SEL_W = 2;

endpackage : mux_arb_pkg

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Round-robin pick: finds the first set request bit starting at ptr and
// wrapping modulo N_REQ. Purely combinational.
//   req     : request vector, bit i = requester i
//   ptr     : highest-priority requester index for this pick
//   gnt_idx : index of the chosen requester (0 when nothing requests)
//   any     : at least one request bit set
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             any
);

    logic [SEL_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest hit to ptr wins.
    always_comb begin
        gnt_idx = '0;
        idx     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ptr + SEL_W'(k);
            if (req[idx]) begin
                gnt_idx = idx;
            end
        end
    end

    assign any = |req;

endmodule : rr_pick

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter steering four valid/ready requesters onto one
// downstream channel through a shared 4:1 mux. A grant lasts up to
// MAX_BURST accepted beats or until the granted requester drops valid;
// every release passes through IDLE before the next grant.
//   clk, rst   : clock, synchronous active-high reset
//   req_valid  : per-requester valid
//   req_data   : requester i data at [i*DATA_W +: DATA_W]
//   req_ready  : per-requester ready, one-hot or zero
//   out_valid  : downstream valid (combinational from granted requester)
//   out_data   : downstream data = slice chosen by select
//   out_ready  : downstream ready
//   select     : registered mux select, current/last granted requester
//   busy       : high while in GRANT
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        select,
    output logic                    busy
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t       state_q, state_d;
    logic [SEL_W-1:0] select_q, select_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic [SEL_W-1:0] pick_idx;
    logic             pick_any;
    logic             in_grant;
    logic             sel_valid;
    logic             accept;
    logic [DATA_W-1:0] data_arr [N_REQ];

    // Unpack the flat data bus so the mux indexes by requester.
    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end

    rr_pick u_rr_pick (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // State and bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            select_q   <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            select_q   <= select_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Handshake steering; gated by rst so nothing is accepted in a reset cycle.
    always_comb begin
        in_grant  = (state_q == GRANT);
        sel_valid = req_valid[select_q];
        out_valid = in_grant && sel_valid && !rst;
        accept    = out_valid && out_ready;
        req_ready = '0;
        if (in_grant && !rst) begin
            req_ready[select_q] = out_ready;
        end
        out_data  = data_arr[select_q];
        busy      = in_grant;
        select    = select_q;
    end

    // Next-state: arbitrate in IDLE, count beats and decide release in GRANT.
    always_comb begin
        state_d    = state_q;
        select_d   = select_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    select_d   = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (!sel_valid) begin
                    state_d  = IDLE;
                    rr_ptr_d = select_q + SEL_W'(1);
                end else if (accept) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (beat_cnt_q == CNT_W'(MAX_BURST - 1)) begin
                        state_d  = IDLE;
                        rr_ptr_d = select_q + SEL_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule : mux_rr_arbiter

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter (DATA_W=8, MAX_BURST=4).
module tb_mux_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic [1:0]  select;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] dat [4];

    mux_rr_arbiter #(.DATA_W(8), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .select    (select),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_idle(input string tag);
        #1;
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_ovld"},  32'(out_valid), 32'd0);
        chk({tag, "_rrdy"},  32'(req_ready), 32'd0);
    endtask

    task automatic expect_beat(input string tag, input int g);
        logic [3:0] oh;
        oh = 4'b0001 << g;
        #1;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_sel"},  32'(select), 32'(g));
        chk({tag, "_ovld"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, 32'(out_data), 32'(dat[g]));
        chk({tag, "_rrdy"}, 32'(req_ready), 32'(oh));
    endtask

    initial begin
        int order [5];
        order = '{0, 1, 2, 3, 0};
        dat[0] = 8'h10; dat[1] = 8'h21; dat[2] = 8'hA5; dat[3] = 8'h3C;
        req_data  = {dat[3], dat[2], dat[1], dat[0]};
        rst       = 1'b1;
        req_valid = 4'b1111;
        out_ready = 1'b1;

        // 1. reset held with all requesting
        step();
        for (int c = 0; c < 2; c++) begin
            chk("rst_ovld", 32'(out_valid), 32'd0);
            chk("rst_rrdy", 32'(req_ready), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_sel",  32'(select), 32'd0);
            step();
        end
        req_valid = 4'b0000;
        #1;
        chk("rst_sel_low", 32'(select), 32'd0);
        chk("rst_data",    32'(out_data), 32'(dat[0]));
        rst = 1'b0;
        step();

        // 2. single requester 2, full burst then bubble and regrant
        req_valid = 4'b0100;
        expect_idle("s2_arb");
        step();
        for (int b = 0; b < 4; b++) begin
            expect_beat("s2_beat", 2);
            step();
        end
        expect_idle("s2_bubble");
        step();
        chk("s2_regrant_busy", 32'(busy), 32'd1);
        chk("s2_regrant_sel",  32'(select), 32'd2);
        req_valid = 4'b0000;
        #1;
        chk("s2_drop_ovld", 32'(out_valid), 32'd0);
        step();

        // 3. all requesting from a fresh pointer
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            expect_idle("s3_bubble");
            step();
            for (int b = 0; b < 4; b++) begin
                expect_beat("s3_beat", order[k]);
                step();
            end
        end

        // 4. backpressure on requester 1
        req_valid = 4'b0010;
        out_ready = 1'b0;
        expect_idle("s4_arb");
        step();
        for (int c = 0; c < 5; c++) begin
            chk("s4_stall_busy", 32'(busy), 32'd1);
            chk("s4_stall_sel",  32'(select), 32'd1);
            chk("s4_stall_ovld", 32'(out_valid), 32'd1);
            chk("s4_stall_rrdy", 32'(req_ready), 32'd0);
            chk("s4_stall_data", 32'(out_data), 32'(dat[1]));
            step();
        end
        out_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            expect_beat("s4_beat", 1);
            step();
        end
        req_valid = 4'b0000;
        expect_idle("s4_release");
        step();

        // 5. requester 3 ends early while 0 waits
        req_valid = 4'b1001;
        expect_idle("s5_arb");
        step();
        for (int b = 0; b < 2; b++) begin
            expect_beat("s5_beat", 3);
            step();
        end
        req_valid = 4'b0001;
        #1;
        chk("s5_drop_busy", 32'(busy), 32'd1);
        chk("s5_drop_ovld", 32'(out_valid), 32'd0);
        step();
        expect_idle("s5_bubble");
        step();
        expect_beat("s5_next", 0);

        // 6. reset mid-burst of requester 2
        req_valid = 4'b0100;
        #1;
        chk("s6_drop_ovld", 32'(out_valid), 32'd0);
        step();
        expect_idle("s6_arb");
        step();
        expect_beat("s6_beat1", 2);
        step();
        rst = 1'b1;
        #1;
        chk("s6_rst_ovld", 32'(out_valid), 32'd0);
        chk("s6_rst_rrdy", 32'(req_ready), 32'd0);
        step();
        rst = 1'b0;
        req_valid = 4'b1111;
        expect_idle("s6_post");
        chk("s6_post_sel",  32'(select), 32'd0);
        chk("s6_post_data", 32'(out_data), 32'(dat[0]));
        step();
        expect_beat("s6_first", 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mux_rr_arbiter
